// File: rtl/pdm_capture_ctrl.sv
// PDM microphone capture controller: divides ahb_clk into the PDM bit clock, deinterleaves one or
// two channels into MSB-first words and streams them to a sample memory. Option: PDM_CAPTURE_HALF_IRQ_EN.

module pdm_capture_ctrl #(
   parameter int WORD_W  = 32,
   parameter int DEPTH   = 49152,
   parameter int ADDR_W  = 16,
   parameter int NUM_CH  = 2,
   parameter int CLK_DIV = 16
) (
   input  logic              ahb_clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              continuous,
   input  logic              pdm_data,
   output logic              pdm_clk_o,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WORD_W-1:0] wr_data,
   output logic              wr_ch,
   output logic              bsy,
   output logic              done
`ifdef PDM_CAPTURE_HALF_IRQ_EN
   ,
   output logic              half_irq
`endif
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int BIT_W = $clog2(WORD_W);

   localparam logic [DIV_W-1:0]  DIV_MID   = DIV_W'(CLK_DIV/2 - 1);
   localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV/2);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
   localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

   if (CLK_DIV < 4 || (CLK_DIV % 2) != 0) begin : g_bad_div
      $error("pdm_capture_ctrl: CLK_DIV must be even and at least 4");
   end
   if (NUM_CH != 1 && NUM_CH != 2) begin : g_bad_ch
      $error("pdm_capture_ctrl: NUM_CH must be 1 or 2");
   end
   if ((2**ADDR_W) < DEPTH || (NUM_CH == 2 && (DEPTH % 2) != 0)) begin : g_bad_depth
      $error("pdm_capture_ctrl: DEPTH does not fit ADDR_W or is odd in stereo mode");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [DIV_W-1:0]  div_cnt, div_nxt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [ADDR_W-1:0] addr;
   logic              mode_cont;

   // Only WORD_W-1 history bits are kept; the live pdm_data bit completes the word.
   logic [WORD_W-2:0] sr0, sr1;
   logic [WORD_W-1:0] word0, word1;

   logic start_ok, in_run, last_bit, smp0, smp1, emit0, emit1, last_wr;

   assign in_run   = (state == RUN);
   assign start_ok = (state == IDLE) & start & ~abort;
   assign last_bit = (bit_cnt == BIT_LAST);
   assign smp0     = in_run & ~abort & (div_cnt == DIV_MID);
   assign smp1     = in_run & ~abort & (NUM_CH == 2) & (div_cnt == DIV_LAST);
   assign emit0    = smp0 & last_bit;
   assign emit1    = smp1 & last_bit;
   assign word0    = {sr0, pdm_data};
   assign word1    = {sr1, pdm_data};
   assign last_wr  = wr_en & (wr_addr == ADDR_LAST);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge ahb_clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
   always_comb begin
      state_nxt = state;
      bsy       = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) state_nxt = RUN;
         end
         RUN: begin
            bsy = 1'b1;
            if (abort)                      state_nxt = IDLE;
            else if (last_wr && !mode_cont) state_nxt = FIN;
         end
         FIN: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The divider restarts from 0 on entering RUN and is parked at 0 outside it.
   always_comb begin
      div_nxt = '0;
      if (in_run && state_nxt == RUN)
         div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_ONE;
   end

   always_ff @(posedge ahb_clk or posedge rst) begin
      if (rst) begin
         div_cnt   <= '0;
         pdm_clk_o <= 1'b0;
         bit_cnt   <= '0;
         sr0       <= '0;
         sr1       <= '0;
         addr      <= '0;
         mode_cont <= 1'b0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         wr_ch     <= 1'b0;
      end else begin
         div_cnt   <= div_nxt;
         pdm_clk_o <= (state_nxt == RUN) && (div_nxt < DIV_HALF);
         wr_en     <= 1'b0;
         if (start_ok) begin
            bit_cnt   <= '0;
            sr0       <= '0;
            sr1       <= '0;
            addr      <= '0;
            mode_cont <= continuous;
         end else if (in_run && !abort) begin
            if (div_cnt == DIV_LAST)
               bit_cnt <= last_bit ? '0 : bit_cnt + BIT_ONE;
            if (smp0) sr0 <= word0[WORD_W-2:0];
            if (smp1) sr1 <= word1[WORD_W-2:0];
            // Channel 0 and channel 1 completions are CLK_DIV/2 apart, so they never collide.
            if (emit0 || emit1) begin
               wr_en   <= 1'b1;
               wr_addr <= addr;
               wr_data <= emit1 ? word1 : word0;
               wr_ch   <= emit1;
               addr    <= (addr == ADDR_LAST) ? '0 : addr + ADDR_ONE;
            end
         end
      end
   end

`ifdef PDM_CAPTURE_HALF_IRQ_EN
   localparam logic [ADDR_W-1:0] ADDR_HALF = ADDR_W'(DEPTH/2 - 1);

   // Fires after each half of the buffer is written, letting software drain ping-pong halves.
   always_ff @(posedge ahb_clk or posedge rst) begin
      if (rst) half_irq <= 1'b0;
      else     half_irq <= wr_en && (wr_addr == ADDR_HALF || wr_addr == ADDR_LAST);
   end
`endif

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Directed self-checking bench for pdm_capture_ctrl: a stereo instance and a mono instance share
// stimulus; PDM data is generated from a cycle count relative to the accepted start.

module tb_pdm_capture_ctrl;

   localparam int WORD_W  = 8;
   localparam int DEPTH   = 8;
   localparam int ADDR_W  = 4;
   localparam int CLK_DIV = 4;

   logic ahb_clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic continuous = 1'b0;
   logic pdm_data = 1'b0;

   logic              pdm_clk_o, wr_en, wr_ch, bsy, done;
   logic [ADDR_W-1:0] wr_addr;
   logic [WORD_W-1:0] wr_data;
   logic              m_pdm_clk_o, m_wr_en, m_wr_ch, m_bsy, m_done;
   logic [ADDR_W-1:0] m_wr_addr;
   logic [WORD_W-1:0] m_wr_data;
`ifdef PDM_CAPTURE_HALF_IRQ_EN
   logic half_irq, m_half_irq;
`endif

   pdm_capture_ctrl #(.WORD_W(WORD_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NUM_CH(2), .CLK_DIV(CLK_DIV)) u_dut (
      .ahb_clk(ahb_clk), .rst(rst), .start(start), .abort(abort), .continuous(continuous),
      .pdm_data(pdm_data), .pdm_clk_o(pdm_clk_o), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_ch(wr_ch), .bsy(bsy), .done(done)
`ifdef PDM_CAPTURE_HALF_IRQ_EN
      , .half_irq(half_irq)
`endif
   );

   pdm_capture_ctrl #(.WORD_W(WORD_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NUM_CH(1), .CLK_DIV(CLK_DIV)) u_mono (
      .ahb_clk(ahb_clk), .rst(rst), .start(start), .abort(abort), .continuous(continuous),
      .pdm_data(pdm_data), .pdm_clk_o(m_pdm_clk_o), .wr_en(m_wr_en), .wr_addr(m_wr_addr),
      .wr_data(m_wr_data), .wr_ch(m_wr_ch), .bsy(m_bsy), .done(m_done)
`ifdef PDM_CAPTURE_HALF_IRQ_EN
      , .half_irq(m_half_irq)
`endif
   );

   always #5 ahb_clk = ~ahb_clk;

   int cyc = 0;
   int t0 = 0;
   int n_tests = 0;
   int n_fail = 0;
   logic [7:0] pat0 = 8'h00;
   logic [7:0] pat1 = 8'h00;

   typedef struct {
      int                cyc;
      logic [ADDR_W-1:0] addr;
      logic [WORD_W-1:0] data;
      logic              ch;
   } wr_t;

   wr_t wq[$];
   wr_t mq[$];
   int  dq[$];
   int  mdq[$];
   int  hq[$];
   int  mhq[$];

   always @(posedge ahb_clk) cyc = cyc + 1;

   // Microphone model: period p of the capture carries bit 7-(p%8) of pat0 in the high phase
   // and of pat1 in the low phase.
   always @(negedge ahb_clk) begin : mic
      int k, p;
      k = cyc - t0 - 1;
      if (k >= 0) begin
         p = (k / CLK_DIV) % 8;
         pdm_data = ((k % CLK_DIV) < CLK_DIV/2) ? pat0[7-p] : pat1[7-p];
      end
   end

   always @(negedge ahb_clk) begin : logger
      if (wr_en)   wq.push_back('{cyc, wr_addr, wr_data, wr_ch});
      if (m_wr_en) mq.push_back('{cyc, m_wr_addr, m_wr_data, m_wr_ch});
      if (done)    dq.push_back(cyc);
      if (m_done)  mdq.push_back(cyc);
`ifdef PDM_CAPTURE_HALF_IRQ_EN
      if (half_irq)   hq.push_back(cyc);
      if (m_half_irq) mhq.push_back(cyc);
`endif
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      wq.delete(); mq.delete(); dq.delete(); mdq.delete(); hq.delete(); mhq.delete();
   endtask

   // Called at a negedge; the cycle after the accepting edge is relative cycle 1.
   task automatic go(input logic cont);
      clear_logs();
      t0 = cyc;
      start = 1'b1;
      continuous = cont;
      @(negedge ahb_clk);
      start = 1'b0;
      continuous = 1'b0;
   endtask

   task automatic wait_rel(input int r);
      while (cyc - t0 < r) @(negedge ahb_clk);
   endtask

   task automatic check_stereo(input string tag, input logic [7:0] d0, input logic [7:0] d1, input int nwr);
      check({tag, " count"}, wq.size(), nwr);
      for (int j = 0; j < nwr && j < wq.size(); j++) begin
         check($sformatf("%s cyc%0d", tag, j), wq[j].cyc - t0, 31 + 32*(j/2) + 2*(j%2));
         check($sformatf("%s addr%0d", tag, j), wq[j].addr, j % 8);
         check($sformatf("%s data%0d", tag, j), wq[j].data, (j % 2) ? d1 : d0);
         check($sformatf("%s ch%0d", tag, j), wq[j].ch, j % 2);
      end
   endtask

   task automatic check_mono(input string tag, input logic [7:0] d0, input int nwr);
      check({tag, " count"}, mq.size(), nwr);
      for (int j = 0; j < nwr && j < mq.size(); j++) begin
         check($sformatf("%s cyc%0d", tag, j), mq[j].cyc - t0, 31 + 32*j);
         check($sformatf("%s addr%0d", tag, j), mq[j].addr, j % 8);
         check($sformatf("%s data%0d", tag, j), mq[j].data, d0);
         check($sformatf("%s ch%0d", tag, j), mq[j].ch, 0);
      end
   endtask

   initial begin
      // 1: reset held with start toggling
      for (int i = 0; i < 4; i++) begin
         @(negedge ahb_clk);
         start = ~start;
         check("rst outs", {pdm_clk_o, wr_en, wr_ch, bsy, done, wr_addr, wr_data}, 0);
         check("rst mono outs", {m_pdm_clk_o, m_wr_en, m_wr_ch, m_bsy, m_done, m_wr_addr, m_wr_data}, 0);
      end
      start = 1'b0;
      @(negedge ahb_clk);
      rst = 1'b0;
      repeat (3) @(negedge ahb_clk);
      check("idle after rst", {bsy, pdm_clk_o, wr_en, done}, 0);

      // 2: one-shot stereo, ch0 all ones, ch1 all zeros
      pat0 = 8'hFF; pat1 = 8'h00;
      go(1'b0);
      wait_rel(10);  check("t2 pdm_clk hi", pdm_clk_o, 1); check("t2 bsy", bsy, 1);
      wait_rel(12);  check("t2 pdm_clk lo", pdm_clk_o, 0);
      wait_rel(129); check("t2 bsy last wr", bsy, 1);
      wait_rel(130); check("t2 done", done, 1); check("t2 bsy fin", bsy, 0);
      wait_rel(131); check("t2 done end", done, 0); check("t2 bsy end", bsy, 0);
      wait_rel(300);
      check_stereo("t2", 8'hFF, 8'h00, 8);
      check("t2 done count", dq.size(), 1);
      if (dq.size() > 0) check("t2 done cyc", dq[0] - t0, 130);
      check("t2 hold addr", wr_addr, 7);
      check("t2 hold wr_en", wr_en, 0);

      // 3: one-shot alternating pattern, stereo and mono
      pat0 = 8'hAA; pat1 = 8'h3C;
      go(1'b0);
      wait_rel(300);
      check_stereo("t3", 8'hAA, 8'h3C, 8);
      check_mono("t3m", 8'hAA, 8);
      check("t3m done count", mdq.size(), 1);
      if (mdq.size() > 0) check("t3m done cyc", mdq[0] - t0, 256);

      // 4: continuous with wrap, then abort
      pat0 = 8'h81; pat1 = 8'h7E;
      go(1'b1);
      wait_rel(150); check("t4 bsy", bsy, 1);
      wait_rel(198); check("t4 pdm_clk pre", pdm_clk_o, 1);
      abort = 1'b1;
      @(negedge ahb_clk);
      abort = 1'b0;
      check("t4 bsy abort", bsy, 0);
      check("t4 pdm_clk abort", pdm_clk_o, 0);
      wait_rel(300);
      check_stereo("t4", 8'h81, 8'h7E, 12);
      check("t4 no done", dq.size(), 0);
      check_mono("t4m", 8'h81, 6);
`ifdef PDM_CAPTURE_HALF_IRQ_EN
      check("t4 half count", hq.size(), 3);
      for (int j = 0; j < 3 && j < hq.size(); j++)
         check($sformatf("t4 half%0d", j), hq[j] - t0, 66 + 64*j);
      check("t4m half count", mhq.size(), 1);
      if (mhq.size() > 0) check("t4m half cyc", mhq[0] - t0, 128);
`endif

      // 5: abort mid-word, then restart
      pat0 = 8'hFF; pat1 = 8'hFF;
      go(1'b0);
      wait_rel(18);
      abort = 1'b1;
      @(negedge ahb_clk);
      abort = 1'b0;
      wait_rel(40);
      check("t5 no partial wr", wq.size(), 0);
      check("t5 no done", dq.size(), 0);
      check("t5 idle", bsy, 0);
      pat0 = 8'h5A; pat1 = 8'hC3;
      go(1'b0);
      wait_rel(300);
      check_stereo("t5", 8'h5A, 8'hC3, 8);

      // reset in the middle of a capture
      pat0 = 8'hFF; pat1 = 8'h00;
      go(1'b0);
      wait_rel(40);
      check("t6 bsy", bsy, 1);
      check("t6 addr", wr_addr, 1);
      rst = 1'b1;
      #1;
      check("t6 async rst", {pdm_clk_o, wr_en, wr_ch, bsy, done, wr_addr, wr_data}, 0);
      @(negedge ahb_clk);
      rst = 1'b0;
      repeat (3) @(negedge ahb_clk);
      check("t6 idle", {bsy, pdm_clk_o, wr_en}, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
